// File: rtl/pwm_regs.sv
// pwm_regs: register-mapped PWM generator fed by a simple cs/wr/rd bus.
//
// Register map (byte addresses):
//   0x0 CTRL   bit0 = enable, other bits read back as 0
//   0x4 PERIOD shadow period, moved to the active copy on a period wrap
//   0x8 DUTY   shadow duty, moved to the active copy on a period wrap
//   0xC COUNT  live counter, read-only
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   adr          byte address
//   cs/wr/rd     chip select, write strobe, read strobe (write wins if both)
//   d_in         write data
//   d_out        registered read data, holds when no read occurs
//   pwm_out      registered PWM waveform
//   period_tick  one-cycle pulse in the cycle the counter reads 0 after a wrap
//
// Run state machine:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | enable clear: counter/output held at 0, actives track shadows
//   ST_RUN  | enable set, active period nonzero: counting and generating
//   ST_HOLD | enable set, active period zero: output 0, actives track shadows

module pwm_regs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] adr,
    input  logic              cs,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              pwm_out,
    output logic              period_tick
);

    localparam logic [ADDR_W-1:0] ADR_CTRL   = ADDR_W'('h0);
    localparam logic [ADDR_W-1:0] ADR_PERIOD = ADDR_W'('h4);
    localparam logic [ADDR_W-1:0] ADR_DUTY   = ADDR_W'('h8);
    localparam logic [ADDR_W-1:0] ADR_COUNT  = ADDR_W'('hC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ctrl_en_q, ctrl_en_d;
    logic [DATA_W-1:0] period_sh_q, period_sh_d;
    logic [DATA_W-1:0] duty_sh_q, duty_sh_d;
    logic [DATA_W-1:0] period_act_q, period_act_d;
    logic [DATA_W-1:0] duty_act_q, duty_act_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic              pwm_q, pwm_d;
    logic              tick_q, tick_d;

    logic              wr_en;
    logic              rd_en;

    assign wr_en = cs & wr;
    assign rd_en = cs & rd & ~wr;

    // Bus side: shadow writes and registered read data.
    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        d_out_d     = d_out_q;

        if (wr_en) begin
            case (adr)
                ADR_CTRL:   ctrl_en_d   = d_in[0];
                ADR_PERIOD: period_sh_d = d_in;
                ADR_DUTY:   duty_sh_d   = d_in;
                default:    ;
            endcase
        end

        if (rd_en) begin
            case (adr)
                ADR_CTRL:   d_out_d = {{(DATA_W-1){1'b0}}, ctrl_en_q};
                ADR_PERIOD: d_out_d = period_sh_q;
                ADR_DUTY:   d_out_d = duty_sh_q;
                ADR_COUNT:  d_out_d = cnt_q;
                default:    d_out_d = '0;
            endcase
        end
    end

    // Run side: counter, output and active-register reloads.
    always_comb begin
        cnt_d        = cnt_q;
        pwm_d        = pwm_q;
        tick_d       = tick_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;

        case (state_q)
            ST_RUN: begin
                pwm_d = (cnt_q < duty_act_q);
                // period_act_q is never 0 in ST_RUN, so the subtraction cannot wrap.
                if (cnt_q == period_act_q - DATA_W'(1)) begin
                    cnt_d        = '0;
                    tick_d       = 1'b1;
                    period_act_d = period_sh_q;
                    duty_act_d   = duty_sh_q;
                end else begin
                    cnt_d  = cnt_q + DATA_W'(1);
                    tick_d = 1'b0;
                end
            end
            default: begin
                cnt_d        = '0;
                pwm_d        = 1'b0;
                tick_d       = 1'b0;
                period_act_d = period_sh_q;
                duty_act_d   = duty_sh_q;
            end
        endcase
    end

    // The state follows the registers it will be judged against, so the
    // mode always matches the enable bit and active period of the same cycle.
    always_comb begin
        state_d = ST_IDLE;
        if (ctrl_en_d) begin
            if (period_act_d == '0) state_d = ST_HOLD;
            else                    state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ctrl_en_q    <= 1'b0;
            period_sh_q  <= '0;
            duty_sh_q    <= '0;
            period_act_q <= '0;
            duty_act_q   <= '0;
            cnt_q        <= '0;
            d_out_q      <= '0;
            pwm_q        <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_en_q    <= ctrl_en_d;
            period_sh_q  <= period_sh_d;
            duty_sh_q    <= duty_sh_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            cnt_q        <= cnt_d;
            d_out_q      <= d_out_d;
            pwm_q        <= pwm_d;
            tick_q       <= tick_d;
        end
    end

    assign d_out       = d_out_q;
    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule
